// File: rtl/shared_response_memory.sv
// Shared R-beat store: one pool of beat entries threaded into per-UID linked
// lists, with a free list, single-cycle per-UID flush and occupancy reporting.
module shared_response_memory #(
   parameter int NUM_UIDS          = 16,
   parameter int ID_WIDTH          = 4,
   parameter int POOL_DEPTH        = 32,
   parameter int MAX_BEATS_PER_UID = 8,
   parameter int DATA_WIDTH        = 64,
   parameter int RESP_WIDTH        = 2,
   localparam int PTR_W            = $clog2(POOL_DEPTH),
   localparam int CNT_W            = $clog2(POOL_DEPTH + 1),
   localparam int UCNT_W           = $clog2(MAX_BEATS_PER_UID + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ID_WIDTH-1:0]   in_id,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [RESP_WIDTH-1:0] in_resp,
   input  logic                  in_last,
   input  logic                  alloc_req,
   input  logic [ID_WIDTH-1:0]   uid_to_alloc,
   input  logic                  free_req,
   input  logic [ID_WIDTH-1:0]   uid_to_free,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ID_WIDTH-1:0]   out_id,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [RESP_WIDTH-1:0] out_resp,
   output logic                  out_last,
   output logic                  free_ack,
   output logic [CNT_W-1:0]      free_count,
   output logic [NUM_UIDS-1:0]   uid_full
);

   localparam logic [UCNT_W-1:0] MAX_CNT  = UCNT_W'(MAX_BEATS_PER_UID);
   localparam logic [UCNT_W-1:0] ONE_U    = UCNT_W'(1);
   localparam logic [CNT_W-1:0]  POOL_CNT = CNT_W'(POOL_DEPTH);
   localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);

   // Per-UID list state and pool link array.
   logic [UCNT_W-1:0] cnt_q  [NUM_UIDS];
   logic [UCNT_W-1:0] cnt_d  [NUM_UIDS];
   logic [PTR_W-1:0]  head_q [NUM_UIDS];
   logic [PTR_W-1:0]  head_d [NUM_UIDS];
   logic [PTR_W-1:0]  tail_q [NUM_UIDS];
   logic [PTR_W-1:0]  tail_d [NUM_UIDS];
   logic [PTR_W-1:0]  next_q [POOL_DEPTH];
   logic [PTR_W-1:0]  next_d [POOL_DEPTH];

   // Free list: head/tail are meaningless while fcnt_q == 0.
   logic [PTR_W-1:0]  fhead_q, fhead_d, ftail_q, ftail_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;

   // Beat payload RAM, not reset.
   logic [DATA_WIDTH-1:0] mem_data [POOL_DEPTH];
   logic [RESP_WIDTH-1:0] mem_resp [POOL_DEPTH];
   logic                  mem_last [POOL_DEPTH];

   logic             flush_elig, flush_hit, accept, pop;
   logic [PTR_W-1:0] pop_ptr;
   logic [PTR_W-1:0] fh, ft;
   logic [CNT_W-1:0] fc;

   // Handshakes: a beat transfers on a cycle where in_valid & in_ready; the head
   // beat transfers when out_valid & out_ready (signalled as free_ack). in_ready
   // may look at in_valid/alloc_req so that flushing an at-cap UID is accepted.
   always_comb begin
      flush_elig = alloc_req & in_valid & (uid_to_alloc == in_id);
      in_ready   = (fcnt_q != '0) & ((cnt_q[in_id] < MAX_CNT) | flush_elig);
      accept     = in_valid & in_ready;
      flush_hit  = flush_elig & in_ready;
      pop_ptr    = head_q[uid_to_free];
      out_valid  = free_req & (cnt_q[uid_to_free] != '0)
                   & ~(flush_hit & (uid_to_alloc == uid_to_free));
      pop        = out_valid & out_ready;
      free_ack   = pop;
      out_id     = uid_to_free;
      out_data   = out_valid ? mem_data[pop_ptr] : '0;
      out_resp   = out_valid ? mem_resp[pop_ptr] : '0;
      out_last   = out_valid & mem_last[pop_ptr];
      free_count = fcnt_q;
   end

   // Occupancy flags straight from the registered per-UID counts.
   always_comb begin
      for (int u = 0; u < NUM_UIDS; u++) uid_full[u] = (cnt_q[u] == MAX_CNT);
   end

   // Next list state: take free head for the write, then append flushed list
   // and popped entry (in that order) to the free tail, then link the new beat.
   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      next_d = next_q;
      fc = fcnt_q - CNT_W'(accept);
      fh = accept ? next_q[fhead_q] : fhead_q;
      ft = ftail_q;
      if (flush_hit && cnt_q[in_id] != '0) begin
         if (fc == '0) fh = head_q[in_id];
         else          next_d[ft] = head_q[in_id];
         ft = tail_q[in_id];
         fc = fc + CNT_W'(cnt_q[in_id]);
      end
      if (pop) begin
         if (fc == '0) fh = pop_ptr;
         else          next_d[ft] = pop_ptr;
         ft = pop_ptr;
         fc = fc + ONE_C;
         head_d[uid_to_free] = next_q[pop_ptr];
         cnt_d[uid_to_free]  = cnt_q[uid_to_free] - ONE_U;
      end
      if (accept) begin
         if (flush_hit || cnt_d[in_id] == '0) begin
            head_d[in_id] = fhead_q;
            cnt_d[in_id]  = ONE_U;
         end else begin
            next_d[tail_q[in_id]] = fhead_q;
            cnt_d[in_id]          = cnt_d[in_id] + ONE_U;
         end
         tail_d[in_id] = fhead_q;
      end
      fhead_d = fh;
      ftail_d = ft;
      fcnt_d  = fc;
   end

   // List and free-list registers; reset rebuilds the free list as 0..N-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int u = 0; u < NUM_UIDS; u++) begin
            cnt_q[u]  <= '0;
            head_q[u] <= '0;
            tail_q[u] <= '0;
         end
         for (int i = 0; i < POOL_DEPTH; i++) next_q[i] <= PTR_W'(i + 1);
         fhead_q <= '0;
         ftail_q <= PTR_W'(POOL_DEPTH - 1);
         fcnt_q  <= POOL_CNT;
      end else begin
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         next_q  <= next_d;
         fhead_q <= fhead_d;
         ftail_q <= ftail_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Payload write into the entry taken from the free head.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_data[fhead_q] <= in_data;
         mem_resp[fhead_q] <= in_resp;
         mem_last[fhead_q] <= in_last;
      end
   end

endmodule

// File: tb/tb_shared_response_memory.sv
// Directed bench for shared_response_memory: vector table plus hand sequences.
module tb_shared_response_memory;

   localparam int NUM_UIDS = 16;
   localparam int ID_W     = 4;
   localparam int POOL     = 32;
   localparam int MAXB     = 8;
   localparam int DW       = 64;
   localparam int RW       = 2;
   localparam int CNT_W    = 6;

   logic            clk, rst;
   logic            in_valid, in_ready, in_last;
   logic [ID_W-1:0] in_id, uid_to_alloc, uid_to_free, out_id;
   logic [DW-1:0]   in_data, out_data;
   logic [RW-1:0]   in_resp, out_resp;
   logic            alloc_req, free_req, out_valid, out_ready, out_last, free_ack;
   logic [CNT_W-1:0]    free_count;
   logic [NUM_UIDS-1:0] uid_full;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];

   shared_response_memory #(
      .NUM_UIDS(NUM_UIDS), .ID_WIDTH(ID_W), .POOL_DEPTH(POOL),
      .MAX_BEATS_PER_UID(MAXB), .DATA_WIDTH(DW), .RESP_WIDTH(RW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
      .in_data(in_data), .in_resp(in_resp), .in_last(in_last),
      .alloc_req(alloc_req), .uid_to_alloc(uid_to_alloc),
      .free_req(free_req), .uid_to_free(uid_to_free),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_data(out_data), .out_resp(out_resp), .out_last(out_last),
      .free_ack(free_ack), .free_count(free_count), .uid_full(uid_full)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      logic          in_valid;
      logic [3:0]    in_id;
      logic [63:0]   in_data;
      logic          in_last;
      logic          free_req;
      logic [3:0]    uid_to_free;
      logic          out_ready;
      logic          exp_in_ready;
      logic          exp_out_valid;
      logic [63:0]   exp_out_data;
      logic          exp_out_last;
      logic          exp_free_ack;
      logic [5:0]    exp_free_count;
      logic [15:0]   exp_uid_full;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic iv, input logic [3:0] id, input logic [63:0] d,
                               input logic l, input logic fr, input logic [3:0] uf,
                               input logic ordy, input logic e_ir, input logic e_ov,
                               input logic [63:0] e_d, input logic e_l, input logic e_ack,
                               input logic [5:0] e_fc, input logic [15:0] e_full);
      vec_t v;
      v.in_valid = iv; v.in_id = id; v.in_data = d; v.in_last = l;
      v.free_req = fr; v.uid_to_free = uf; v.out_ready = ordy;
      v.exp_in_ready = e_ir; v.exp_out_valid = e_ov; v.exp_out_data = e_d;
      v.exp_out_last = e_l; v.exp_free_ack = e_ack; v.exp_free_count = e_fc;
      v.exp_uid_full = e_full;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      in_valid = 0; in_id = 0; in_data = 0; in_resp = 0; in_last = 0;
      alloc_req = 0; uid_to_alloc = 0; free_req = 0; uid_to_free = 0; out_ready = 0;
   endtask

   task automatic wr(input logic [3:0] id, input logic [63:0] d, input logic last);
      set_idle();
      in_valid = 1; in_id = id; in_data = d; in_resp = d[1:0]; in_last = last;
      #1;
      check($sformatf("wr uid%0d in_ready", id), in_ready, 1);
      tick();
      set_idle();
   endtask

   task automatic pop_chk(input logic [3:0] id, input logic [63:0] d);
      set_idle();
      free_req = 1; uid_to_free = id; out_ready = 1;
      #1;
      check($sformatf("pop uid%0d out_valid", id), out_valid, 1);
      check($sformatf("pop uid%0d out_data", id), out_data, d);
      check($sformatf("pop uid%0d free_ack", id), free_ack, 1);
      tick();
      set_idle();
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      // Reset state
      set_idle();
      rst = 1;
      #2;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset free_ack", free_ack, 0);
      check("reset free_count", free_count, 32);
      check("reset uid_full", uid_full, 0);
      tick();
      rst = 0;

      // Table: fill UID 3 to cap, blocked 9th beat, stalled pop, drain in order
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(1, 3, 64'h10 + k, k == 7, 0, 0, 0,
                           1, 0, 0, 0, 0, 6'(32 - k), 16'h0000));
      vecs.push_back(mk(1, 3, 64'h18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 24, 16'h0008));
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 1, 1, 64'h10, 0, 0, 24, 16'h0008));
      vecs.push_back(mk(0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 0, 0, 24, 16'h0008));
      for (int j = 0; j < 8; j++)
         vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 1, 64'h10 + j, j == 7, 1,
                           6'(24 + j), (j == 0) ? 16'h0008 : 16'h0000));
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 32, 16'h0000));

      for (int i = 0; i < vecs.size(); i++) begin
         set_idle();
         in_valid = vecs[i].in_valid; in_id = vecs[i].in_id;
         in_data = vecs[i].in_data; in_resp = vecs[i].in_data[1:0];
         in_last = vecs[i].in_last; free_req = vecs[i].free_req;
         uid_to_free = vecs[i].uid_to_free; out_ready = vecs[i].out_ready;
         #1;
         check($sformatf("v%0d in_ready", i), in_ready, vecs[i].exp_in_ready);
         check($sformatf("v%0d out_valid", i), out_valid, vecs[i].exp_out_valid);
         check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_out_data);
         check($sformatf("v%0d out_resp", i), out_resp,
               vecs[i].exp_out_valid ? vecs[i].exp_out_data[1:0] : 2'b00);
         check($sformatf("v%0d out_last", i), out_last, vecs[i].exp_out_last);
         check($sformatf("v%0d out_id", i), out_id, vecs[i].uid_to_free);
         check($sformatf("v%0d free_ack", i), free_ack, vecs[i].exp_free_ack);
         check($sformatf("v%0d free_count", i), free_count, vecs[i].exp_free_count);
         check($sformatf("v%0d uid_full", i), uid_full, vecs[i].exp_uid_full);
         tick();
      end
      set_idle();

      // Pool exhaustion: 8 beats to each of UIDs 0..3
      do_reset();
      for (int u = 0; u < 4; u++)
         for (int b = 0; b < 8; b++) wr(4'(u), 64'(u * 16 + b), b == 7);
      check("fill free_count", free_count, 0);
      check("fill uid_full", uid_full, 16'h000F);
      in_valid = 1; in_id = 5; in_data = 64'h5A; in_resp = 2'b10;
      free_req = 1; uid_to_free = 0; out_ready = 1;
      #1;
      check("fill uid5 blocked", in_ready, 0);
      check("fill pop0 out_data", out_data, 64'h00);
      check("fill pop0 free_ack", free_ack, 1);
      tick();
      free_req = 0; out_ready = 0;
      #1;
      check("fill free_count after pop", free_count, 1);
      check("fill uid5 ready", in_ready, 1);
      tick();
      set_idle();
      #1;
      check("fill free_count refilled", free_count, 0);
      pop_chk(5, 64'h5A);
      pop_chk(0, 64'h01);

      // Flush with a concurrent pop on another UID
      do_reset();
      wr(1, 64'h31, 1);
      for (int b = 0; b < 5; b++) wr(2, 64'h20 + b, b == 4);
      check("flush pre free_count", free_count, 26);
      in_valid = 1; in_id = 2; in_data = 64'hAA; in_resp = 2'b10; in_last = 1;
      alloc_req = 1; uid_to_alloc = 2;
      free_req = 1; uid_to_free = 2; out_ready = 1;
      #1;
      check("flush in_ready", in_ready, 1);
      check("flush same-uid pop masked", out_valid, 0);
      check("flush same-uid free_ack", free_ack, 0);
      uid_to_free = 1;
      #1;
      check("flush other pop out_valid", out_valid, 1);
      check("flush other pop out_data", out_data, 64'h31);
      tick();
      set_idle();
      #1;
      check("flush free_count", free_count, 31);
      pop_chk(2, 64'hAA);
      free_req = 1; uid_to_free = 2;
      #1;
      check("flush uid2 single beat", out_valid, 0);
      set_idle();
      check("flush free_count restored", free_count, 32);

      // Flushing an at-cap UID is accepted
      for (int b = 0; b < 8; b++) wr(6, 64'h60 + b, b == 7);
      in_valid = 1; in_id = 6; in_data = 64'h6F; in_resp = 2'b11;
      #1;
      check("cap plain beat blocked", in_ready, 0);
      alloc_req = 1; uid_to_alloc = 6;
      #1;
      check("cap flush beat ready", in_ready, 1);
      tick();
      set_idle();
      #1;
      check("cap flush free_count", free_count, 31);
      check("cap flush uid_full", uid_full, 0);
      pop_chk(6, 64'h6F);

      // Walk the whole pool through the spliced free list
      for (int u = 8; u < 12; u++)
         for (int b = 0; b < 8; b++) begin
            wr(4'(u), 64'(u * 16 + b), b == 7);
            exp_q.push_back(64'(u * 16 + b));
         end
      check("walk free_count empty", free_count, 0);
      for (int u = 8; u < 12; u++)
         for (int b = 0; b < 8; b++) pop_chk(4'(u), exp_q.pop_front());
      check("walk free_count full", free_count, 32);

      // free_count == 1 with write and pop on different UIDs
      do_reset();
      wr(4, 64'h44, 1);
      for (int u = 8; u < 11; u++)
         for (int b = 0; b < 8; b++) wr(4'(u), 64'(u * 16 + b), b == 7);
      for (int b = 0; b < 6; b++) wr(11, 64'hB0 + b, 0);
      check("one-free free_count", free_count, 1);
      in_valid = 1; in_id = 1; in_data = 64'h55; in_resp = 2'b01;
      free_req = 1; uid_to_free = 4; out_ready = 1;
      #1;
      check("one-free in_ready", in_ready, 1);
      check("one-free pop data", out_data, 64'h44);
      check("one-free free_ack", free_ack, 1);
      tick();
      set_idle();
      #1;
      check("one-free free_count after", free_count, 1);
      pop_chk(1, 64'h55);
      check("one-free free_count final", free_count, 2);

      // Write and pop on the same UID holding one beat
      do_reset();
      wr(7, 64'h77, 1);
      in_valid = 1; in_id = 7; in_data = 64'h99; in_resp = 2'b01;
      free_req = 1; uid_to_free = 7; out_ready = 1;
      #1;
      check("same-uid in_ready", in_ready, 1);
      check("same-uid old head", out_data, 64'h77);
      tick();
      set_idle();
      #1;
      check("same-uid free_count", free_count, 31);
      pop_chk(7, 64'h99);
      free_req = 1; uid_to_free = 7;
      #1;
      check("same-uid count was 1", out_valid, 0);
      set_idle();

      // Asynchronous reset mid-burst
      do_reset();
      for (int b = 0; b < 3; b++) wr(5, 64'hA0 + b, 0);
      free_req = 1; uid_to_free = 5;
      #1;
      check("midrst before out_valid", out_valid, 1);
      check("midrst before out_data", out_data, 64'hA0);
      rst = 1;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst out_data", out_data, 0);
      check("midrst free_count", free_count, 32);
      check("midrst in_ready", in_ready, 1);
      tick();
      rst = 0;
      #1;
      check("midrst list gone", out_valid, 0);
      set_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/shared_response_memory.md
Name: shared_response_memory

Overview:
- Next-generation R-beat store. Per-UID storage is replaced by one shared beat pool of POOL_DEPTH entries.
- Each UID owns a linked list threaded through the pool, capped at MAX_BEATS_PER_UID beats.
- Sits between the fabric R channel and the ordering unit. Adds an O(1) per-UID flush and occupancy reporting.
- Pop interface is combinational head-of-list, as in the current per-UID memory.

Parameters:
- NUM_UIDS, 16, number of independent UID lists.
- ID_WIDTH, 4, UID width; 2**ID_WIDTH >= NUM_UIDS.
- POOL_DEPTH, 32, total shared beat entries; >= 2.
- MAX_BEATS_PER_UID, 8, per-UID occupancy cap; 1 to POOL_DEPTH.
- DATA_WIDTH, 64, R data width.
- RESP_WIDTH, 2, R resp width.
- Derived: PTR_W = $clog2(POOL_DEPTH), CNT_W = $clog2(POOL_DEPTH+1), UCNT_W = $clog2(MAX_BEATS_PER_UID+1).

Ports:
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  incoming beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_id  in  ID_WIDTH  beat UID
- in_data  in  DATA_WIDTH  beat data
- in_resp  in  RESP_WIDTH  beat response
- in_last  in  1  beat last flag
- alloc_req  in  1  start-of-burst marker for uid_to_alloc
- uid_to_alloc  in  ID_WIDTH  UID to flush/restart
- free_req  in  1  request head beat of uid_to_free
- uid_to_free  in  ID_WIDTH  UID to pop
- out_valid  out  1  head beat available
- out_ready  in  1  consumer accepts head
- out_id  out  ID_WIDTH  equals uid_to_free
- out_data  out  DATA_WIDTH  head data, zero when !out_valid
- out_resp  out  RESP_WIDTH  head resp, zero when !out_valid
- out_last  out  1  head last, zero when !out_valid
- free_ack  out  1  out_valid & out_ready (pop this cycle)
- free_count  out  CNT_W  registered number of free pool entries
- uid_full  out  NUM_UIDS  bit u = count[u] == MAX_BEATS_PER_UID

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-high (clk, rst).

Reset (asserted any time, including mid-burst):
- All UID lists empty: count 0, head/tail don't-care.
- Free list = entries 0..POOL_DEPTH-1 in order, next[i] = i+1.
- free_count = POOL_DEPTH.
- Outputs settle to: in_ready=1, out_valid=0, free_ack=0, uid_full=0.
- Data RAM is not reset.

Flush:
- flush_hit = alloc_req & (uid_to_alloc == in_id) & in_valid & in_ready.
- A flush only takes effect together with an accepted beat; alloc_req without an accepted matching beat is ignored.
- On flush_hit with count[in_id] > 0, the whole old list is spliced onto the free-list tail in one cycle.

Write acceptance:
- in_ready = (free_count > 0) & (count[in_id] < MAX_BEATS_PER_UID | flush_hit-eligible).
- Flushing an at-cap UID is therefore accepted.
- Accepted beat takes the free-list head entry, writes data/resp/last, and links at the UID tail.
- If the list is empty or being flushed, the entry becomes both head and tail and count = 1; otherwise count + 1.

Pop:
- out_valid = free_req & count[uid_to_free] > 0 & !(flush_hit & uid_to_alloc == uid_to_free).
- Output fields come from the head entry.
- On free_ack: head advances to next[head], count - 1, and the freed entry is appended to the free-list tail.

Simultaneous events, all resolved in one cycle:
- Write allocation uses the free head as of cycle start; entries freed this cycle are usable next cycle.
- With free_count == 1, a concurrent write and pop leave exactly the popped entry free.
- Write and pop on the same UID: count unchanged. If count was 1, the new beat becomes both head and tail.
- Flush and pop on different UIDs: both splices are appended to the free tail, flushed list first, then popped entry.

free_count:
- Next value = free_count − accept + pop + flushed_count.
- Never exceeds POOL_DEPTH; never underflows, since acceptance requires free_count > 0.

Latency:
- Accepted beat is poppable the next cycle.
- Pop is zero-latency combinational from free_req/uid_to_free.

Test Plan:
- After reset, 8 beats on UID 3 (data 0x10..0x17, last on 8th) -> free_count 24, uid_full[3]=1, 9th beat sees in_ready=0; pop 8 with out_ready=1 -> data 0x10..0x17 in order, last on final pop, free_count 32.
- Fill pool: 8 beats to each of UIDs 0–3 -> free_count 0, in_ready=0 for UID 5; one pop of UID 0 -> next cycle UID 5 beat accepted, free_count returns to 0.
- UID 2 holds 5 beats; beat 0xAA on UID 2 with alloc_req, uid_to_alloc=2 -> free_count +4 net, count[2]=1, next pop returns 0xAA.
- free_count==1, same cycle write UID 1 (0x55) and pop UID 4 -> free_count stays 1, next cycle UID 1 pop returns 0x55.
- UID 7 count 1, same cycle write 0x99 and pop UID 7 -> pop returns old head, then 0x99 available, count 1.
- Assert rst mid-burst with 3 beats queued -> out_valid=0 immediately (async), free_count=32, prior data unreachable.
